sync_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO, 16 entries × 8 bits, with occupancy flags. It buffers bytes between a producer writing with single-cycle strobes and a consumer (the UART transmitter) that reads the head entry combinationally and pops it with a single-cycle read strobe. Storage is distributed RAM; all control state runs in one clock domain.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 27 ++
 rtl/sync_fifo.sv | 80 ++++++++
 tb/tb_sync_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the byte FIFO feeding the UART transmitter.
package fifo_pkg;

  parameter int unsigned DATA_WIDTH = 8;
  parameter int unsigned ADDR_WIDTH = 4;
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH;
  parameter int unsigned HALF       = DEPTH / 2;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Distributed RAM: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // No reset on the array so it maps onto LUT RAM.
  logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy flags decoded from a registered count.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataPresent,
  output logic                  halfFull,
  output logic                  full
);
  import fifo_pkg::*;

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CntFull = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0]   CntHalf = (ADDR_WIDTH + 1)'(Depth / 2);
  localparam logic [ADDR_WIDTH:0]   CntOne  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // A full FIFO still takes a write when the same edge frees a slot.
  assign push = write && (!full || read);
  assign pop  = read && dataPresent;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) begin
      wp_d = wp_q + PtrOne;
    end
    if (pop) begin
      rp_d = rp_q + PtrOne;
    end
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wp_q),
    .wdata(dataIn),
    .raddr(rp_q),
    .rdata(ram_rdata)
  );

  assign dataPresent = (count_q != '0);
  assign halfFull    = (count_q >= CntHalf);
  assign full        = (count_q == CntFull);
  // Stale RAM contents are never exposed while empty.
  assign dataOut     = dataPresent ? ram_rdata : '0;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic [7:0] dataOut;
  logic       dataPresent, halfFull, full;

  int passed = 0;
  int total  = 0;

  sync_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .read       (read),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .dataPresent(dataPresent),
    .halfFull   (halfFull),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    write = 1'b1; dataIn = d; read = 1'b0;
    tick();
    write = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      read = 1'b1;
      tick();
    end
    read = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if ({dataPresent, halfFull, full} !== 3'b000) $display("FAIL por_flags: got %b want 000", {dataPresent, halfFull, full}); else passed++;
    total++; if (dataOut !== 8'h00) $display("FAIL por_data: got %h want 00", dataOut); else passed++;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    total++; if (dataPresent !== 1'b1) $display("FAIL pre_reset_present: got %b want 1", dataPresent); else passed++;
    #1;
    rst = 1'b0;
    #1;
    total++; if ({dataPresent, halfFull, full} !== 3'b000) $display("FAIL mid_reset_flags: got %b want 000", {dataPresent, halfFull, full}); else passed++;
    total++; if (dataOut !== 8'h00) $display("FAIL mid_reset_data: got %h want 00", dataOut); else passed++;
    #1;
    rst = 1'b1;
    push(8'hA5);
    total++; if (dataOut !== 8'hA5) $display("FAIL reset_then_write_data: got %h want a5", dataOut); else passed++;
    total++; if (dataPresent !== 1'b1) $display("FAIL reset_then_write_present: got %b want 1", dataPresent); else passed++;
    read = 1'b1; tick(); read = 1'b0;
    total++; if (dataPresent !== 1'b0) $display("FAIL reset_single_drain: got %b want 0", dataPresent); else passed++;
  endtask

  task automatic test_fill_order();
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      total++; if (halfFull !== (i >= 7)) $display("FAIL fill_half_%0d: got %b want %b", i + 1, halfFull, (i >= 7)); else passed++;
      total++; if (full !== (i == 15)) $display("FAIL fill_full_%0d: got %b want %b", i + 1, full, (i == 15)); else passed++;
    end
    push(8'hFF);
    total++; if (full !== 1'b1) $display("FAIL overflow_full: got %b want 1", full); else passed++;
    total++; if (dataOut !== 8'h00) $display("FAIL overflow_head: got %h want 00", dataOut); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++; if (dataOut !== 8'(i)) $display("FAIL order_%0d: got %h want %h", i, dataOut, 8'(i)); else passed++;
      read = 1'b1; tick(); read = 1'b0;
      total++; if (halfFull !== (15 - i >= 8)) $display("FAIL drain_half_%0d: got %b want %b", i, halfFull, (15 - i >= 8)); else passed++;
      total++; if (dataPresent !== (i != 15)) $display("FAIL drain_present_%0d: got %b want %b", i, dataPresent, (i != 15)); else passed++;
      total++; if (full !== 1'b0) $display("FAIL drain_full_%0d: got %b want 0", i, full); else passed++;
    end
    total++; if (dataOut !== 8'h00) $display("FAIL drained_data: got %h want 00", dataOut); else passed++;
  endtask

  task automatic test_empty_read();
    read = 1'b1; tick(); read = 1'b0;
    total++; if (dataPresent !== 1'b0) $display("FAIL empty_read_present: got %b want 0", dataPresent); else passed++;
    total++; if (dataOut !== 8'h00) $display("FAIL empty_read_data: got %h want 00", dataOut); else passed++;
    push(8'h3C);
    total++; if (dataOut !== 8'h3C) $display("FAIL empty_read_then_write: got %h want 3c", dataOut); else passed++;
    read = 1'b1; tick(); read = 1'b0;
    total++; if (dataPresent !== 1'b0) $display("FAIL empty_read_count1: got %b want 0", dataPresent); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      push(8'h10 + 8'(i));
      q.push_back(8'h10 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      total++; if (dataOut !== q[0]) $display("FAIL rw3_head_%0d: got %h want %h", i, dataOut, q[0]); else passed++;
      d = 8'h20 + 8'(i);
      write = 1'b1; read = 1'b1; dataIn = d;
      tick();
      void'(q.pop_front());
      q.push_back(d);
    end
    write = 1'b0; read = 1'b0;
    total++; if ({dataPresent, halfFull} !== 2'b10) $display("FAIL rw3_flags: got %b want 10", {dataPresent, halfFull}); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (dataOut !== q[0]) $display("FAIL rw3_tail_%0d: got %h want %h", i, dataOut, q[0]); else passed++;
      void'(q.pop_front());
      read = 1'b1; tick(); read = 1'b0;
    end
    total++; if (dataPresent !== 1'b0) $display("FAIL rw3_count: got %b want 0", dataPresent); else passed++;

    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    total++; if (dataOut !== 8'h40) $display("FAIL rwfull_head: got %h want 40", dataOut); else passed++;
    write = 1'b1; read = 1'b1; dataIn = 8'h99;
    tick();
    write = 1'b0; read = 1'b0;
    total++; if (full !== 1'b1) $display("FAIL rwfull_full: got %b want 1", full); else passed++;
    total++; if (dataOut !== 8'h41) $display("FAIL rwfull_next: got %h want 41", dataOut); else passed++;
    for (int i = 0; i < 16; i++) begin
      d = (i == 15) ? 8'h99 : 8'h41 + 8'(i);
      total++; if (dataOut !== d) $display("FAIL rwfull_drain_%0d: got %h want %h", i, dataOut, d); else passed++;
      read = 1'b1; tick(); read = 1'b0;
    end

    write = 1'b1; read = 1'b1; dataIn = 8'h77;
    tick();
    write = 1'b0; read = 1'b0;
    total++; if (dataOut !== 8'h77) $display("FAIL rwempty_data: got %h want 77", dataOut); else passed++;
    total++; if (dataPresent !== 1'b1) $display("FAIL rwempty_present: got %b want 1", dataPresent); else passed++;
    read = 1'b1; tick(); read = 1'b0;
    total++; if (dataPresent !== 1'b0) $display("FAIL rwempty_count1: got %b want 0", dataPresent); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] d;
    logic       wr, rd;
    int         pushed;
    int         errs;
    d = 8'($urandom);
    push(d);
    q.push_back(d);
    pushed = 1;
    errs = 0;
    for (int it = 0; it < 400 && pushed < 40; it++) begin
      wr = (q.size() < 15) ? 1'($urandom) : 1'b0;
      rd = (q.size() > 1) ? 1'($urandom) : 1'b0;
      d = 8'($urandom);
      if (dataOut !== q[0]) begin
        errs++;
        $display("FAIL wrap_head_%0d: got %h want %h", it, dataOut, q[0]);
      end
      write = wr; read = rd; dataIn = d;
      tick();
      if (rd) void'(q.pop_front());
      if (wr) begin
        q.push_back(d);
        pushed++;
      end
    end
    write = 1'b0; read = 1'b0;
    while (q.size() > 0) begin
      if (dataOut !== q[0]) begin
        errs++;
        $display("FAIL wrap_drain: got %h want %h", dataOut, q[0]);
      end
      void'(q.pop_front());
      read = 1'b1; tick(); read = 1'b0;
    end
    total++; if (errs != 0) $display("FAIL wrap_stream: got %0d bad bytes want 0", errs); else passed++;
    total++; if (pushed != 40) $display("FAIL wrap_budget: got %0d pushes want 40", pushed); else passed++;
    total++; if (dataPresent !== 1'b0) $display("FAIL wrap_empty: got %b want 0", dataPresent); else passed++;
  endtask

  task automatic test_flag_boundaries();
    for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
    write = 1'b1; dataIn = 8'h87;
    #1;
    total++; if (halfFull !== 1'b0) $display("FAIL half_before_edge: got %b want 0", halfFull); else passed++;
    tick(); write = 1'b0;
    total++; if (halfFull !== 1'b1) $display("FAIL half_7to8: got %b want 1", halfFull); else passed++;
    read = 1'b1;
    #1;
    total++; if (halfFull !== 1'b1) $display("FAIL half_read_before_edge: got %b want 1", halfFull); else passed++;
    tick(); read = 1'b0;
    total++; if (halfFull !== 1'b0) $display("FAIL half_8to7: got %b want 0", halfFull); else passed++;
    for (int i = 0; i < 8; i++) push(8'h90 + 8'(i));
    total++; if (full !== 1'b0) $display("FAIL full_at15: got %b want 0", full); else passed++;
    write = 1'b1; dataIn = 8'h9F;
    #1;
    total++; if (full !== 1'b0) $display("FAIL full_before_edge: got %b want 0", full); else passed++;
    tick(); write = 1'b0;
    total++; if (full !== 1'b1) $display("FAIL full_15to16: got %b want 1", full); else passed++;
    read = 1'b1; tick(); read = 1'b0;
    total++; if (full !== 1'b0) $display("FAIL full_16to15: got %b want 0", full); else passed++;
    total++; if (dataOut !== 8'h82) $display("FAIL full_head_after_pop: got %h want 82", dataOut); else passed++;
    drain();
  endtask

  initial begin
    test_reset();
    test_fill_order();
    test_empty_read();
    test_back_to_back();
    test_wrap();
    test_flag_boundaries();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
